peripheral_arbiter: RTL and testbench

//  Shares the single uncached peripheral bridge between two requesters: port 0 = pipeline data-side

---
 rtl/peripheral_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_peripheral_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_arbiter.sv
// Round-robin arbiter that shares the uncached peripheral bridge between
// the pipeline data side (port 0) and the debug/DMA master (port 1).
// Only one transaction is in flight at a time. The bridge gets a one-cycle
// START pulse, and its DONE level is acknowledged with a one-cycle DONE_ACK.
// A watchdog forces a hung transaction to complete with ERR.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; clear stale DONE first, else grant a request
// ISSUE   | PERI_START high for this single cycle, watchdog loaded
// WAIT    | waiting for PERI_DONE or watchdog expiry
// RELEASE | completion reported; wait for the bridge to drop DONE

module peripheral_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] ADDR1,
  input  logic              WRITE0,
  input  logic              WRITE1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              ACK0,
  output logic              ACK1,
  output logic              ERR,
  output logic [DATA_W-1:0] RDATA,
  output logic              PERI_START,
  output logic [DATA_W-1:0] PERI_ADDRESS,
  output logic              PERI_WRITE,
  output logic [DATA_W-1:0] PERI_DATA_IN,
  input  logic [DATA_W-1:0] PERI_DATA_OUT,
  input  logic              PERI_DONE,
  output logic              PERI_DONE_ACK
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Watchdog is a down-counter; expiry on reaching zero after TIMEOUT
  // WAIT cycles, i.e. the same instant an up-count would hit TIMEOUT-1.
  localparam logic [TO_W-1:0] WD_LOAD = TO_W'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            rr_ptr;     // port preferred on the next grant
  logic            grant;      // port owning the current transaction
  logic            txn_open;   // set from grant until RELEASE exits
  logic            dack_sent;  // DONE_ACK was pulsed on the way into RELEASE
  logic [TO_W-1:0] wd_cnt;

  logic            any_req;
  logic            grant_nxt;
  logic            issue_go;
  logic            stale_hit;
  logic            done_hit;
  logic            to_hit;
  logic            wd_expired;
  logic            release_exit;

  // Request selection, completion qualifiers and watchdog terminal count
  always_comb begin
    any_req    = REQ0 | REQ1;
    grant_nxt  = rr_ptr;
    if (rr_ptr == 1'b0) begin
      grant_nxt = REQ0 ? 1'b0 : 1'b1;
    end else begin
      grant_nxt = REQ1 ? 1'b1 : 1'b0;
    end
    wd_expired   = (wd_cnt == '0);
    stale_hit    = (state == ST_IDLE) && PERI_DONE;
    issue_go     = (state == ST_IDLE) && !PERI_DONE && any_req;
    done_hit     = (state == ST_WAIT) && PERI_DONE;
    to_hit       = (state == ST_WAIT) && !PERI_DONE && wd_expired;
    // After a timeout no DONE_ACK was sent, so RELEASE must not wait on a
    // DONE that may rise late; IDLE clears such a DONE through the stale path.
    release_exit = (state == ST_RELEASE) && (!PERI_DONE || !dack_sent);
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (stale_hit) begin
          state_nxt = ST_RELEASE;
        end else if (issue_go) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_hit || to_hit) begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (release_exit) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant capture and request latch towards the bridge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      grant        <= 1'b0;
      PERI_ADDRESS <= '0;
      PERI_WRITE   <= 1'b0;
      PERI_DATA_IN <= '0;
    end else if (issue_go) begin
      grant        <= grant_nxt;
      PERI_ADDRESS <= grant_nxt ? ADDR1  : ADDR0;
      PERI_WRITE   <= grant_nxt ? WRITE1 : WRITE0;
      PERI_DATA_IN <= grant_nxt ? WDATA1 : WDATA0;
    end
  end

  // One-cycle START pulse in the cycle after the grant
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PERI_START <= 1'b0;
    end else begin
      PERI_START <= issue_go;
    end
  end

  // Watchdog: loaded while issuing, counts down through WAIT
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wd_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      wd_cnt <= WD_LOAD;
    end else if ((state == ST_WAIT) && !wd_expired) begin
      wd_cnt <= wd_cnt - 1'b1;
    end
  end

  // Completion pulses to the requester and the bridge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ACK0          <= 1'b0;
      ACK1          <= 1'b0;
      ERR           <= 1'b0;
      PERI_DONE_ACK <= 1'b0;
    end else begin
      ACK0          <= (done_hit | to_hit) & ~grant;
      ACK1          <= (done_hit | to_hit) & grant;
      ERR           <= to_hit;
      PERI_DONE_ACK <= done_hit | stale_hit;
    end
  end

  // Load data capture; stores and timeouts leave RDATA untouched
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RDATA <= '0;
    end else if (done_hit && !PERI_WRITE) begin
      RDATA <= PERI_DATA_OUT;
    end
  end

  // Remember whether RELEASE owes the bridge a DONE drop
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dack_sent <= 1'b0;
    end else if (state != ST_RELEASE) begin
      dack_sent <= done_hit | stale_hit;
    end
  end

  // Round-robin pointer moves only when a granted transaction is released,
  // so a stale-DONE cleanup never disturbs the fairness order
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      txn_open <= 1'b0;
      rr_ptr   <= 1'b0;
    end else if (issue_go) begin
      txn_open <= 1'b1;
    end else if (release_exit) begin
      txn_open <= 1'b0;
      if (txn_open) begin
        rr_ptr <= ~grant;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_arbiter.sv
// Bench for peripheral_arbiter: directed requests, a behavioural bridge,
// and a scoreboard monitor that checks every START and every ACK.

module tb_peripheral_arbiter;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 20;
  localparam int TO_W    = 5;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              REQ0, REQ1;
  logic [DATA_W-1:0] ADDR0, ADDR1;
  logic              WRITE0, WRITE1;
  logic [DATA_W-1:0] WDATA0, WDATA1;
  logic              ACK0, ACK1, ERR;
  logic [DATA_W-1:0] RDATA;
  logic              PERI_START;
  logic [DATA_W-1:0] PERI_ADDRESS;
  logic              PERI_WRITE;
  logic [DATA_W-1:0] PERI_DATA_IN;
  logic [DATA_W-1:0] PERI_DATA_OUT = '0;
  logic              PERI_DONE = 1'b0;
  logic              PERI_DONE_ACK;

  always #5 CLK = ~CLK;

  peripheral_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WRITE0(WRITE0), .WRITE1(WRITE1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .ERR(ERR), .RDATA(RDATA),
    .PERI_START(PERI_START), .PERI_ADDRESS(PERI_ADDRESS), .PERI_WRITE(PERI_WRITE),
    .PERI_DATA_IN(PERI_DATA_IN), .PERI_DATA_OUT(PERI_DATA_OUT),
    .PERI_DONE(PERI_DONE), .PERI_DONE_ACK(PERI_DONE_ACK)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } st_t;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    logic [15:0] lat;
  } ak_t;

  st_t st_q[$];
  ak_t ak_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int start_cnt = 0;
  int dack_cnt  = 0;

  // bridge controls (written only by the stimulus process)
  int          br_delay = 1;
  logic        br_xor   = 1'b0;
  logic [31:0] br_data  = '0;
  int          inject_req = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_start(input logic [31:0] a, input logic w, input logic [31:0] d);
    st_q.push_back('{addr: a, write: w, wdata: d});
  endtask

  task automatic push_ack(input logic p, input logic e, input logic [31:0] r, input int lat);
    ak_q.push_back('{port: p, err: e, rdata: r, lat: 16'(lat)});
  endtask

  task automatic req_on(input int p, input logic [31:0] a, input logic w, input logic [31:0] d);
    if (p == 0) begin
      REQ0 = 1'b1; ADDR0 = a; WRITE0 = w; WDATA0 = d;
    end else begin
      REQ1 = 1'b1; ADDR1 = a; WRITE1 = w; WDATA1 = d;
    end
  endtask

  task automatic wait_ack(input int p);
    int g = 0;
    do begin
      @(negedge CLK);
      g++;
    end while (((p == 0) ? !ACK0 : !ACK1) && g < 200);
    chk((p == 0) ? "ack0_wait" : "ack1_wait", 64'(g < 200), 64'd1);
    if (p == 0) REQ0 = 1'b0;
    else        REQ1 = 1'b0;
  endtask

  task automatic do_req(input int p, input logic [31:0] a, input logic w, input logic [31:0] d);
    @(negedge CLK);
    req_on(p, a, w, d);
    wait_ack(p);
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  // Behavioural bridge: DONE br_delay cycles after START (never if <= 0),
  // dropped the cycle after DONE_ACK; inject_req forces a late DONE.
  initial begin
    int   br_cnt = 0;
    logic br_clr = 1'b0;
    int   inject_ack = 0;
    forever begin
      @(negedge CLK);
      if (PERI_DONE_ACK) begin
        br_clr = 1'b1;
      end else if (br_clr) begin
        PERI_DONE = 1'b0;
        br_clr    = 1'b0;
      end
      if (inject_req != inject_ack) begin
        inject_ack    = inject_req;
        PERI_DONE     = 1'b1;
        PERI_DATA_OUT = 32'h57A1_E000;
      end
      if (PERI_START) begin
        if (br_delay > 0) br_cnt = br_delay;
      end else if (br_cnt > 0) begin
        br_cnt--;
        if (br_cnt == 0) begin
          PERI_DONE     = 1'b1;
          PERI_DATA_OUT = br_xor ? (PERI_ADDRESS ^ 32'hFFFF_0000) : br_data;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT starts or acknowledges
  initial begin
    logic outstanding = 1'b0;
    st_t  s;
    ak_t  e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        outstanding = 1'b0;
      end else begin
        if (PERI_START) begin
          start_cnt++;
          chk("start_while_busy", 64'(outstanding), 64'd0);
          if (st_q.size() == 0) begin
            chk("unexpected_start", 64'd1, 64'd0);
          end else begin
            s = st_q.pop_front();
            chk("peri_address", 64'(PERI_ADDRESS), 64'(s.addr));
            chk("peri_write",   64'(PERI_WRITE),   64'(s.write));
            chk("peri_data_in", 64'(PERI_DATA_IN), 64'(s.wdata));
          end
          outstanding = 1'b1;
          start_cyc   = cyc;
        end
        if (ACK0 || ACK1) begin
          chk("ack_onehot", 64'(ACK0 & ACK1), 64'd0);
          if (ak_q.size() == 0) begin
            chk("unexpected_ack", 64'd1, 64'd0);
          end else begin
            e = ak_q.pop_front();
            chk("ack_port",    64'(ACK1),  64'(e.port));
            chk("ack_err",     64'(ERR),   64'(e.err));
            chk("ack_rdata",   64'(RDATA), 64'(e.rdata));
            chk("ack_latency", 64'(cyc - start_cyc), 64'(e.lat));
          end
          if (ERR) outstanding = 1'b0;
        end
        if (PERI_DONE_ACK) begin
          dack_cnt++;
          outstanding = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int g, st0, d0;
    RESET = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    ADDR0 = '0; ADDR1 = '0; WRITE0 = 1'b0; WRITE1 = 1'b0; WDATA0 = '0; WDATA1 = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ctrl",  64'({PERI_START, ACK0, ACK1, ERR, PERI_WRITE, PERI_DONE_ACK}), 64'd0);
    chk("rst_rdata", 64'(RDATA), 64'd0);
    chk("rst_addr",  64'(PERI_ADDRESS), 64'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // contended requests alternate 0,1,0,1 starting from port 0
    br_delay = 1; br_xor = 1'b1;
    push_start(32'h0000_0A00, 1'b0, 32'h0000_00A0);
    push_start(32'h0000_0B04, 1'b1, 32'hBBBB_0001);
    push_start(32'h0000_0A08, 1'b1, 32'hAAAA_0002);
    push_start(32'h0000_0B0C, 1'b0, 32'h0000_00B0);
    push_ack(1'b0, 1'b0, 32'hFFFF_0A00, 2);
    push_ack(1'b1, 1'b0, 32'hFFFF_0A00, 2);
    push_ack(1'b0, 1'b0, 32'hFFFF_0A00, 2);
    push_ack(1'b1, 1'b0, 32'hFFFF_0B0C, 2);
    fork
      begin
        do_req(0, 32'h0000_0A00, 1'b0, 32'h0000_00A0);
        do_req(0, 32'h0000_0A08, 1'b1, 32'hAAAA_0002);
      end
      begin
        do_req(1, 32'h0000_0B04, 1'b1, 32'hBBBB_0001);
        do_req(1, 32'h0000_0B0C, 1'b0, 32'h0000_00B0);
      end
    join

    // single load, bridge answers three cycles after START
    br_delay = 3; br_xor = 1'b0; br_data = 32'hCAFE_F00D;
    st0 = start_cnt; d0 = dack_cnt;
    push_start(32'h4000_0010, 1'b0, 32'h0000_0000);
    push_ack(1'b0, 1'b0, 32'hCAFE_F00D, 4);
    do_req(0, 32'h4000_0010, 1'b0, 32'h0000_0000);
    @(negedge CLK);
    chk("t1_starts",    64'(start_cnt - st0), 64'd1);
    chk("t1_done_acks", 64'(dack_cnt - d0),   64'd1);

    // store that the bridge never completes: watchdog ERR, RDATA kept
    br_delay = -1;
    d0 = dack_cnt;
    push_start(32'h4000_0040, 1'b1, 32'h1234_5678);
    push_ack(1'b1, 1'b1, 32'hCAFE_F00D, TIMEOUT + 1);
    do_req(1, 32'h4000_0040, 1'b1, 32'h1234_5678);
    @(negedge CLK);
    chk("t3_no_done_ack", 64'(dack_cnt - d0), 64'd0);

    // late DONE in IDLE is cleared without ACK; a pending REQ0 waits for it
    @(negedge CLK);
    br_delay = 1; br_data = 32'h0BAD_0004;
    st0 = start_cnt; d0 = dack_cnt;
    inject_req++;
    g = 0;
    while (!PERI_DONE && g < 20) begin
      @(negedge CLK);
      g++;
    end
    chk("t4_late_done_seen", 64'(PERI_DONE), 64'd1);
    push_start(32'h4000_0050, 1'b0, 32'h0000_0000);
    push_ack(1'b0, 1'b0, 32'h0BAD_0004, 2);
    req_on(0, 32'h4000_0050, 1'b0, 32'h0000_0000);
    g = 0;
    while (PERI_DONE && g < 20) begin
      @(negedge CLK);
      g++;
    end
    chk("t4_start_during_done", 64'(start_cnt - st0), 64'd0);
    chk("t4_stale_done_ack",    64'(dack_cnt - d0),   64'd1);
    wait_ack(0);

    // DONE arriving on the last watchdog cycle wins over the timeout
    br_delay = TIMEOUT; br_data = 32'h7E06_0006;
    push_start(32'h4000_0060, 1'b0, 32'h0000_0000);
    push_ack(1'b0, 1'b0, 32'h7E06_0006, TIMEOUT + 1);
    do_req(0, 32'h4000_0060, 1'b0, 32'h0000_0000);

    // reset two cycles after START; the bridge's late DONE is then stale
    repeat (2) @(negedge CLK);
    br_delay = 6; br_data = 32'hDEAD_0005;
    d0 = dack_cnt;
    push_start(32'h4000_0070, 1'b1, 32'h5555_AAAA);
    @(negedge CLK);
    req_on(0, 32'h4000_0070, 1'b1, 32'h5555_AAAA);
    g = 0;
    while (!PERI_START && g < 20) begin
      @(negedge CLK);
      g++;
    end
    chk("t5_start_seen", 64'(PERI_START), 64'd1);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    REQ0  = 1'b0;
    #1;
    chk("t5_rst_ctrl",  64'({PERI_START, ACK0, ACK1, ERR, PERI_WRITE, PERI_DONE_ACK}), 64'd0);
    chk("t5_rst_rdata", 64'(RDATA), 64'd0);
    chk("t5_rst_addr",  64'(PERI_ADDRESS), 64'd0);
    chk("t5_rst_wdata", 64'(PERI_DATA_IN), 64'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    g = 0;
    while (!((dack_cnt > d0) && !PERI_DONE) && g < 40) begin
      @(negedge CLK);
      g++;
    end
    chk("t5_stale_done_ack", 64'(dack_cnt - d0), 64'd1);
    br_delay = 1; br_data = 32'h600D_0006;
    push_start(32'h4000_0080, 1'b0, 32'h0000_0000);
    push_ack(1'b0, 1'b0, 32'h600D_0006, 2);
    do_req(0, 32'h4000_0080, 1'b0, 32'h0000_0000);

    repeat (4) @(negedge CLK);
    chk("start_queue_drained", 64'(st_q.size()), 64'd0);
    chk("ack_queue_drained",   64'(ak_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
